// File: rtl/fifo_umbrales_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO itself (slave).
interface fifo_umbrales_if #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3
);
  logic                       write_enable;
  logic                       read_enable;
  logic [tamano_datos-1:0]    data_in;
  logic [tamano_direcion:0]   umbral_alto;
  logic [tamano_direcion:0]   umbral_bajo;
  logic                       clear_error;
  logic [tamano_datos-1:0]    data_out;
  logic                       valid_out;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       error;
  logic [tamano_direcion:0]   count;

  modport master (
    output write_enable, read_enable, data_in, umbral_alto, umbral_bajo, clear_error,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, error, count
  );

  modport slave (
    input  write_enable, read_enable, data_in, umbral_alto, umbral_bajo, clear_error,
    output data_out, valid_out, full, empty, almost_full, almost_empty, error, count
  );
endinterface

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// registered read data and a sticky overflow/underflow error flag.
module fifo_umbrales #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3
) (
  input  logic            clk,
  input  logic            reset,
  fifo_umbrales_if.slave  bus
);
  localparam int DEPTH = 2 ** tamano_direcion;
  localparam logic [tamano_direcion:0]   FULL_COUNT = (tamano_direcion + 1)'(DEPTH);
  localparam logic [tamano_direcion:0]   COUNT_ONE  = (tamano_direcion + 1)'(1);
  localparam logic [tamano_direcion-1:0] PTR_ONE    = tamano_direcion'(1);

  logic [tamano_datos-1:0]    mem_r [DEPTH];
  logic [tamano_direcion-1:0] wr_ptr_r;
  logic [tamano_direcion-1:0] rd_ptr_r;
  logic [tamano_direcion:0]   count_r;
  logic [tamano_datos-1:0]    data_out_r;
  logic                       valid_out_r;
  logic                       error_r;

  logic is_full_s;
  logic is_empty_s;
  logic rd_acc_s;
  logic wr_acc_s;
  logic overflow_s;
  logic underflow_s;

  // Accept decisions: a read needs stored data (no fall-through); a write may
  // use the slot freed by a same-cycle read even when full.
  always_comb begin
    is_full_s   = (count_r == FULL_COUNT);
    is_empty_s  = (count_r == '0);
    rd_acc_s    = bus.read_enable && !is_empty_s;
    wr_acc_s    = bus.write_enable && (!is_full_s || rd_acc_s);
    overflow_s  = bus.write_enable && is_full_s && !rd_acc_s;
    underflow_s = bus.read_enable && is_empty_s;
  end

  // Storage array; intentionally not reset, only written on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc_s && reset) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        data_out_r <= mem_r[rd_ptr_r];
      end
      valid_out_r <= rd_acc_s;
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
      // A new fault in the same cycle wins over a clear request.
      if (overflow_s || underflow_s) begin
        error_r <= 1'b1;
      end else if (bus.clear_error) begin
        error_r <= 1'b0;
      end
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.valid_out    = valid_out_r;
  assign bus.count        = count_r;
  assign bus.error        = error_r;
  assign bus.full         = is_full_s;
  assign bus.empty        = is_empty_s;
  assign bus.almost_full  = (count_r >= bus.umbral_alto);
  assign bus.almost_empty = (count_r <= bus.umbral_bajo);
endmodule

// File: doc/fifo_umbrales.md
FIFO_UMBRALES -- requirements
Module: fifo_umbrales

Interface
REQ-001 The block SHALL have parameter tamano_datos, default 10: data word width in bits.
REQ-002 The block SHALL have parameter tamano_direcion, default 3: address width, with depth DEPTH = 2**tamano_direcion.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port write_enable, input, 1 bit: write request.
REQ-006 The block SHALL have port read_enable, input, 1 bit: read request.
REQ-007 The block SHALL have port data_in, input, tamano_datos bits: write data.
REQ-008 The block SHALL have port umbral_alto, input, tamano_direcion+1 bits: almost-full threshold; legal range 1..DEPTH.
REQ-009 The block SHALL have port umbral_bajo, input, tamano_direcion+1 bits: almost-empty threshold; legal range 0..DEPTH-1.
REQ-010 The block SHALL have port clear_error, input, 1 bit: clears the sticky error flag.
REQ-011 The block SHALL have port data_out, output, tamano_datos bits: registered read data.
REQ-012 The block SHALL have port valid_out, output, 1 bit: data_out updated by an accepted read in the previous cycle.
REQ-013 The block SHALL have outputs full, empty, almost_full, almost_empty and error, each 1 bit: status flags.
REQ-014 The block SHALL have port count, output, tamano_direcion+1 bits: current occupancy, 0..DEPTH.

Function
REQ-015 The block SHALL store entries in a DEPTH-entry memory addressed by write and read pointers that wrap modulo DEPTH.
REQ-016 The block SHALL accept a write when write_enable=1 and either count<DEPTH or a read is accepted in the same cycle.
REQ-017 The block SHALL accept a read when read_enable=1 and count>0; a read requested at count=0 is never accepted, even if a write is accepted in the same cycle (no fall-through).
REQ-018 On an accepted read, the block SHALL present the entry at the read pointer on data_out at the next edge, with valid_out=1 for exactly that cycle.
REQ-019 When no read is accepted, the block SHALL hold data_out and drive valid_out=0.
REQ-020 The block SHALL update count at each edge as +1 for a write only, -1 for a read only, and unchanged for both or neither.
REQ-021 The block SHALL drive full=(count==DEPTH), empty=(count==0), almost_full=(count>=umbral_alto) and almost_empty=(count<=umbral_bajo) as combinational decodes of the registered count and the current thresholds.
REQ-022 When a write is requested at full with no accepted read (overflow), the block SHALL drop the data, leave the memory and pointers unchanged, and set error.
REQ-023 When a read is requested at empty (underflow), the block SHALL leave data_out unchanged, drive valid_out=0 and set error.
REQ-024 Once set, error SHALL be sticky and SHALL be cleared only by clear_error=1 at a clock edge with no new overflow or underflow in that cycle; a set and a clear in the same cycle SHALL leave error=1.
REQ-025 Threshold values outside their legal ranges SHALL leave behaviour undefined for almost_full and almost_empty only; all other behaviour is unaffected.

Reset
REQ-026 reset=0 at a rising edge SHALL take priority over all other inputs.
REQ-027 On reset, the block SHALL clear both pointers and count to 0, data_out to 0, valid_out to 0 and error to 0.
REQ-028 After reset, the flags SHALL read empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 A reset mid-operation SHALL discard all stored entries; a read in the first cycle after release SHALL be an underflow.

Verification
REQ-031 Fill/drain test (tamano_direcion=3, umbral_alto=6, umbral_bajo=2): write 1..8 -> almost_full at count=6, full at 8; then read 8 -> data_out 1..8 in order, each with valid_out=1 one cycle after its read, empty at 0, error=0.
REQ-032 Overflow test: at full, write 0x3FF with no read -> error=1, count stays 8; draining 8 entries SHALL return no 0x3FF; clear_error -> error=0.
REQ-033 Simultaneous access test: at full, read and write 0x155 together -> count stays 8, full stays 1; 0x155 SHALL be read last after 7 further reads.
REQ-034 Empty test: at empty, read and write 0x0AA together -> error=1, valid_out=0, count=1; the next read SHALL return 0x0AA.
REQ-035 Wrap and reset test: perform 20 mixed writes/reads so the pointers wrap with data order preserved; then assert reset=0 at count=5 -> count=0, empty=1, error=0, data_out=0.
